// File: rtl/intdiv_preproc_pkg.sv
// Shared constants and FSM state type for the integer-divide preprocessor.
package intdiv_preproc_pkg;
  localparam int PAD = 4;   // leading zero bits above |X| in the shifter input
  localparam int W32 = 32;  // active width of W64 (word) ops

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    LZC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // radix R = 2^LOGR
  function automatic int radix(input int logr);
    return 1 << logr;
  endfunction
endpackage

// File: rtl/intdiv_absneg.sv
// Word-op extension of a raw operand, its sign, and its magnitude.
module intdiv_absneg
  import intdiv_preproc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] src,
  input  logic            is_signed,
  input  logic            w64,
  output logic [XLEN-1:0] ext,
  output logic [XLEN-1:0] mag,
  output logic            sgn
);
  localparam int HW = (XLEN > W32) ? W32 : XLEN;

  // extend low word for W64 ops, then negate when the operand is negative
  always_comb begin
    ext = src;
    if (w64) begin
      for (int i = HW; i < XLEN; i++) ext[i] = is_signed & src[HW-1];
    end
    sgn = is_signed & ext[XLEN-1];
    mag = sgn ? -ext : ext;
  end
endmodule

// File: rtl/lzc.sv
// Combinational leading-zero counter; lzc(0) = WIDTH.
module lzc #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]             num,
  output logic [$clog2(WIDTH+1)-1:0]   ZeroCnt
);
  localparam int CW = $clog2(WIDTH+1);

  // scan from the MSB, keep the first one found
  always_comb begin
    logic found;
    found   = 1'b0;
    ZeroCnt = CW'(WIDTH);
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (!found && num[i]) begin
        ZeroCnt = CW'(WIDTH-1-i);
        found   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intdiv_preproc.sv
// Integer-divide preprocessing: |A|,|B|, leading-zero counts, iteration
// count and special-case flags for the normalization shifter / divsqrt FSM.
module intdiv_preproc
  import intdiv_preproc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DIVb    = 64,
  parameter int DIVBLEN = 7,
  parameter int LOGR    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [XLEN-1:0]          SrcA,
  input  logic [XLEN-1:0]          SrcB,
  input  logic                     Signed,
  input  logic                     W64,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic signed [DIVb+3:0]   ShiftInA,
  output logic signed [DIVb+3:0]   ShiftInB,
  output logic [DIVBLEN-1:0]       ShiftAmtA,
  output logic [DIVBLEN-1:0]       ShiftAmtB,
  output logic [DIVBLEN-1:0]       IntCycles,
  output logic                     NegQuot,
  output logic                     NegRem,
  output logic                     DivByZero,
  output logic                     QuotZero,
  output logic                     Overflow
);
  localparam int RADIX = radix(LOGR);
  localparam int OW    = DIVb + PAD;
  localparam int HW    = (XLEN > W32) ? W32 : XLEN;
  localparam int CW    = $clog2(XLEN+1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, absa_q, absa_d, absb_q, absb_d;
  logic              signed_q, signed_d, w64_q, w64_d;
  logic              negquot_q, negquot_d, negrem_q, negrem_d, ovf_q, ovf_d;
  logic              dbz_q, dbz_d, qz_q, qz_d, outvalid_q, outvalid_d;
  logic [DIVBLEN-1:0] shamta_q, shamta_d, shamtb_q, shamtb_d, intcyc_q, intcyc_d;

  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_neg;
  logic              sgn_a, sgn_b;
  logic [CW-1:0]     lzc_a, lzc_b;
  logic [DIVBLEN:0]  span;
  logic [OW-1:0]     sin_a, sin_b;

  intdiv_absneg #(.XLEN(XLEN)) u_absneg_a (
    .src(a_q), .is_signed(signed_q), .w64(w64_q), .ext(ext_a), .mag(mag_a), .sgn(sgn_a)
  );
  intdiv_absneg #(.XLEN(XLEN)) u_absneg_b (
    .src(b_q), .is_signed(signed_q), .w64(w64_q), .ext(ext_b), .mag(mag_b), .sgn(sgn_b)
  );

  lzc #(.WIDTH(XLEN)) u_lzc_a (.num(absa_q), .ZeroCnt(lzc_a));
  lzc #(.WIDTH(XLEN)) u_lzc_b (.num(absb_q), .ZeroCnt(lzc_b));

  // most-negative value at the active width, after extension
  always_comb begin
    min_neg = '0;
    min_neg[XLEN-1] = 1'b1;
    if (w64_q) begin
      for (int i = HW-1; i < XLEN; i++) min_neg[i] = 1'b1;
    end
  end

  // next-state and datapath for the four-state sequencer
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    signed_d   = signed_q;
    w64_d      = w64_q;
    absa_d     = absa_q;
    absb_d     = absb_q;
    negquot_d  = negquot_q;
    negrem_d   = negrem_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    qz_d       = qz_q;
    shamta_d   = shamta_q;
    shamtb_d   = shamtb_q;
    intcyc_d   = intcyc_q;
    outvalid_d = outvalid_q;
    // bcount - acount + 1 + (R-1): rounds up on the shift by LOGR
    span = (DIVBLEN+1)'(lzc_b) - (DIVBLEN+1)'(lzc_a) + (DIVBLEN+1)'(RADIX);
    unique case (state_q)
      IDLE: if (InValid) begin
        a_d      = SrcA;
        b_d      = SrcB;
        signed_d = Signed;
        w64_d    = W64;
        state_d  = ABS;
      end
      ABS: begin
        absa_d    = mag_a;
        absb_d    = mag_b;
        negquot_d = (sgn_a ^ sgn_b) & (ext_b != '0);
        negrem_d  = sgn_a;
        ovf_d     = signed_q & (ext_a == min_neg) & (&ext_b);
        state_d   = LZC;
      end
      LZC: begin
        shamta_d   = DIVBLEN'(lzc_a);
        shamtb_d   = DIVBLEN'(lzc_b);
        dbz_d      = (absb_q == '0);
        qz_d       = !dbz_d & ((lzc_a > lzc_b) | (absa_q < absb_q));
        intcyc_d   = (dbz_d | qz_d | (absa_q == '0)) ? '0 : DIVBLEN'(span >> LOGR);
        outvalid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: if (OutReady) begin
        outvalid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over accept and over consumer handshake
    if (Flush) begin
      state_d    = IDLE;
      outvalid_d = 1'b0;
      if (state_q == IDLE) begin
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        w64_d    = w64_q;
      end
    end
  end

  // state and all output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      signed_q   <= 1'b0;
      w64_q      <= 1'b0;
      absa_q     <= '0;
      absb_q     <= '0;
      negquot_q  <= 1'b0;
      negrem_q   <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      qz_q       <= 1'b0;
      shamta_q   <= '0;
      shamtb_q   <= '0;
      intcyc_q   <= '0;
      outvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      signed_q   <= signed_d;
      w64_q      <= w64_d;
      absa_q     <= absa_d;
      absb_q     <= absb_d;
      negquot_q  <= negquot_d;
      negrem_q   <= negrem_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
      qz_q       <= qz_d;
      shamta_q   <= shamta_d;
      shamtb_q   <= shamtb_d;
      intcyc_q   <= intcyc_d;
      outvalid_q <= outvalid_d;
    end
  end

  assign sin_a     = OW'(absa_q) << (DIVb - XLEN);
  assign sin_b     = OW'(absb_q) << (DIVb - XLEN);
  assign ShiftInA  = sin_a;
  assign ShiftInB  = sin_b;
  assign InReady   = (state_q == IDLE);
  assign OutValid  = outvalid_q;
  assign ShiftAmtA = shamta_q;
  assign ShiftAmtB = shamtb_q;
  assign IntCycles = intcyc_q;
  assign NegQuot   = negquot_q;
  assign NegRem    = negrem_q;
  assign DivByZero = dbz_q;
  assign QuotZero  = qz_q;
  assign Overflow  = ovf_q;
endmodule

// File: tb/tb_intdiv_preproc.sv
// Bench for intdiv_preproc: vector table, random vectors vs a reference
// model, backpressure, flush and asynchronous reset sequences.
module tb_intdiv_preproc;
  logic              clk = 1'b0, reset = 1'b1, Flush = 1'b0, InValid = 1'b0;
  logic              InReady, OutValid, OutReady = 1'b1;
  logic [63:0]       SrcA = '0, SrcB = '0;
  logic              Signed = 1'b0, W64 = 1'b0;
  logic signed [67:0] ShiftInA, ShiftInB;
  logic [6:0]        ShiftAmtA, ShiftAmtB, IntCycles;
  logic              NegQuot, NegRem, DivByZero, QuotZero, Overflow;

  intdiv_preproc dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .SrcA(SrcA), .SrcB(SrcB), .Signed(Signed), .W64(W64), .OutValid(OutValid),
    .OutReady(OutReady), .ShiftInA(ShiftInA), .ShiftInB(ShiftInB),
    .ShiftAmtA(ShiftAmtA), .ShiftAmtB(ShiftAmtB), .IntCycles(IntCycles),
    .NegQuot(NegQuot), .NegRem(NegRem), .DivByZero(DivByZero),
    .QuotZero(QuotZero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic        sgn, w64;
    logic [63:0] ma, mb;
    logic [6:0]  sha, shb, ic;
    logic        nq, nr, dz, qz, ov;
  } vec_t;

  int   n_cmp = 0, n_err = 0;
  vec_t sb[$];
  vec_t tbl[9];

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] a, b, input logic sgn, w64,
                              input logic [63:0] ma, mb, input logic [6:0] sha, shb, ic,
                              input logic nq, nr, dz, qz, ov);
    vec_t v;
    v.a = a; v.b = b; v.sgn = sgn; v.w64 = w64; v.ma = ma; v.mb = mb;
    v.sha = sha; v.shb = shb; v.ic = ic; v.nq = nq; v.nr = nr; v.dz = dz; v.qz = qz; v.ov = ov;
    return v;
  endfunction

  function automatic logic [6:0] nlz(input logic [63:0] x);
    logic [6:0] n = 0;
    logic [63:0] t = x;
    if (x == 0) return 7'd64;
    while (!t[63]) begin t = t << 1; n++; end
    return n;
  endfunction

  // reference model built from the arithmetic definitions
  function automatic vec_t model(input logic [63:0] a, b, input logic sgn, w64);
    logic [63:0] ea, eb, mn;
    logic sa, sbb;
    int   d;
    vec_t v;
    ea = w64 ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
    eb = w64 ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
    sa = sgn && ea[63];
    sbb = sgn && eb[63];
    mn = w64 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    v.a = a; v.b = b; v.sgn = sgn; v.w64 = w64;
    v.ma = sa ? (64'd0 - ea) : ea;
    v.mb = sbb ? (64'd0 - eb) : eb;
    v.sha = nlz(v.ma);
    v.shb = nlz(v.mb);
    v.nq = (sa != sbb) && (eb != 0);
    v.nr = sa;
    v.ov = sgn && (ea == mn) && (eb == 64'hFFFF_FFFF_FFFF_FFFF);
    v.dz = (v.mb == 0);
    v.qz = !v.dz && (v.ma < v.mb);
    d = int'(v.shb) - int'(v.sha) + 1;
    v.ic = (v.dz || v.qz || v.ma == 0) ? 7'd0 : 7'((d + 1) / 2);
    return v;
  endfunction

  task automatic cmp_out(input vec_t e, input string tag);
    check({tag, ".ShiftInA"}, ShiftInA, {4'b0, e.ma});
    check({tag, ".ShiftInB"}, ShiftInB, {4'b0, e.mb});
    check({tag, ".ShiftAmtA"}, 68'(ShiftAmtA), 68'(e.sha));
    check({tag, ".ShiftAmtB"}, 68'(ShiftAmtB), 68'(e.shb));
    check({tag, ".IntCycles"}, 68'(IntCycles), 68'(e.ic));
    check({tag, ".flags"}, 68'({NegQuot, NegRem, DivByZero, QuotZero, Overflow}),
          68'({e.nq, e.nr, e.dz, e.qz, e.ov}));
  endtask

  // drive one request at the accept edge; returns just after that edge
  task automatic start_txn(input vec_t v);
    check("in_ready_before_accept", 68'(InReady), 68'(1));
    SrcA = v.a; SrcB = v.b; Signed = v.sgn; W64 = v.w64; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  // wait for OutValid and pop/compare; enforces the two-edge latency
  task automatic finish_txn(input string tag);
    int   lat = 0;
    vec_t e;
    while (!OutValid && lat < 10) begin @(posedge clk); #1; lat++; end
    check({tag, ".latency"}, 68'(lat), 68'(2));
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 68'(0), 68'(1));
    end else begin
      e = sb.pop_front();
      if (OutValid) cmp_out(e, tag);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    sb.push_back(v);
    start_txn(v);
    finish_txn(tag);
    @(posedge clk); #1;
    check({tag, ".drop_valid"}, 68'({OutValid, InReady}), 68'(2'b01));
  endtask

  initial begin
    vec_t v;
    tbl[0] = mk(64'd100, 64'd7, 0, 0, 64'd100, 64'd7, 57, 61, 3, 0, 0, 0, 0, 0);
    tbl[1] = mk(-64'sd100, 64'd7, 1, 0, 64'd100, 64'd7, 57, 61, 3, 1, 1, 0, 0, 0);
    tbl[2] = mk(64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 64'h8000_0000, 64'd1, 32, 63, 16, 0, 1, 0, 0, 1);
    tbl[3] = mk(64'd5, 64'd0, 0, 0, 64'd5, 64'd0, 61, 64, 0, 0, 0, 1, 0, 0);
    tbl[4] = mk(64'd7, 64'd100, 0, 0, 64'd7, 64'd100, 61, 57, 0, 0, 0, 0, 1, 0);
    tbl[5] = mk(64'd0, 64'd3, 0, 0, 64'd0, 64'd3, 64, 62, 0, 0, 0, 0, 1, 0);
    tbl[6] = mk('1, 64'd1, 0, 0, '1, 64'd1, 0, 63, 32, 0, 0, 0, 0, 0);
    tbl[7] = mk(64'h8000_0000_0000_0000, '1, 1, 0, 64'h8000_0000_0000_0000, 64'd1, 0, 63, 32, 0, 1, 0, 0, 1);
    tbl[8] = mk(-64'sd5, 64'd0, 1, 0, 64'd5, 64'd0, 61, 64, 0, 0, 1, 1, 0, 0);

    // reset state
    #12;
    check("reset.valid_ready", 68'({OutValid, InReady}), 68'(2'b01));
    check("reset.flags", 68'({NegQuot, NegRem, DivByZero, QuotZero, Overflow, IntCycles, ShiftAmtA}), 68'(0));
    #10 reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 12; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i == 5) rb = '0;
      v = model(ra, rb, 1'($urandom), 1'($urandom));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // backpressure: outputs hold, InReady low
    OutReady = 1'b0;
    sb.push_back(tbl[1]);
    start_txn(tbl[1]);
    finish_txn("bp");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp.hold_valid_ready", 68'({OutValid, InReady}), 68'(2'b10));
      cmp_out(tbl[1], "bp.hold");
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    check("bp.release", 68'({OutValid, InReady}), 68'(2'b01));

    // flush in ABS: back to IDLE next edge, no output follows
    start_txn(tbl[0]);
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush.idle", 68'({OutValid, InReady}), 68'(2'b01));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("flush.no_valid", 68'(OutValid), 68'(0));
    end

    // asynchronous reset while in LZC
    start_txn(tbl[2]);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("areset.valid_ready", 68'({OutValid, InReady}), 68'(2'b01));
    check("areset.flags", 68'({NegQuot, NegRem, DivByZero, QuotZero, Overflow, IntCycles}), 68'(0));
    #2 reset = 1'b0;
    #1;
    check("areset.in_ready", 68'(InReady), 68'(1));
    @(posedge clk); #1;
    check("areset.no_valid", 68'(OutValid), 68'(0));

    run_txn(tbl[2], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/intdiv_preproc.md
Name: intdiv_preproc

Overview:
- Integer-divide preprocessing stage that sits directly upstream of the integer normalization shifter in the fdivsqrt unit.
- Accepts raw XLEN operands with op qualifiers, then takes absolute values and counts leading zeros.
- Emits the padded value and shift amount the normalization shifter consumes, plus the iteration count and special-case flags used by the divsqrt FSM.
- Multi-cycle, valid/ready handshaked on both sides.

Parameters:
- XLEN, 64, integer operand width.
- DIVb, 64, fractional datapath width; output operand width is DIVb+4.
- DIVBLEN, 7, width of shift amounts and iteration count; equals clog2(DIVb+1).
- LOGR, 1, log2 of radix; R = 2^LOGR.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Flush  in  1  synchronous abort
- InValid  in  1  operands valid
- InReady  out  1  stage can accept
- SrcA  in  XLEN  dividend
- SrcB  in  XLEN  divisor
- Signed  in  1  signed op (div/rem vs divu/remu)
- W64  in  1  32-bit op on RV64 (divw etc.)
- OutValid  out  1  results valid
- OutReady  in  1  consumer accepts
- ShiftInA  out  DIVb+4  {4'b0, |A|, zero pad}, signed-typed for the shifter
- ShiftInB  out  DIVb+4  same layout for |B|
- ShiftAmtA  out  DIVBLEN  lzc(|A|)
- ShiftAmtB  out  DIVBLEN  lzc(|B|)
- IntCycles  out  DIVBLEN  iterations required
- NegQuot  out  1  quotient must be negated
- NegRem  out  1  remainder must be negated
- DivByZero  out  1  |B| == 0
- QuotZero  out  1  |A| < |B| with B nonzero
- Overflow  out  1  signed most-negative / -1

Behaviour:
- FSM states: IDLE, ABS, LZC, HOLD.
- Reset is asynchronous. It forces IDLE and clears every output register and flag to 0. OutValid=0 and InReady=1 after reset.
- InReady = (state==IDLE). A transfer is accepted when InValid && InReady.
- Accept cycle T: SrcA, SrcB, Signed and W64 are registered; go to ABS.
  - W64=1: operands are the low 32 bits, sign-extended if Signed, else zero-extended.
- ABS (T+1):
  - Sign bits: sA = Signed & A[XLEN-1] and sB likewise.
  - Register |A| and |B|; two's-complement negate when the sign bit is set.
  - NegQuot = sA ^ sB, forced 0 when B==0.
  - NegRem = sA.
  - Overflow = Signed & (A == most-negative at the active width) & (B == all-ones).
  - Go to LZC.
- LZC (T+2):
  - ShiftAmtA = lzc(|A|) and ShiftAmtB = lzc(|B|), counted over the XLEN field. lzc(0)=XLEN.
  - DivByZero = (|B|==0).
  - QuotZero = !DivByZero & (ShiftAmtA > ShiftAmtB or |A|<|B|).
  - IntCycles = ceil((ShiftAmtB - ShiftAmtA + 1)/R); forced 0 if DivByZero, QuotZero or |A|==0.
  - Assert OutValid; go to HOLD.
- HOLD:
  - All outputs stay stable while OutValid && !OutReady.
  - On OutReady: OutValid deasserts next cycle; go to IDLE.
  - No same-cycle re-accept. Minimum initiation interval is 4 cycles.
- Flush in any state: go to IDLE on the next edge, OutValid=0. Data registers may keep stale values.
- Flush has priority over accept and over OutReady.
- Arithmetic in ABS/LZC is unsigned on the absolute values. The most-negative value's magnitude fits because |A| is XLEN-bit unsigned.
- IntCycles width DIVBLEN never overflows: the maximum is ceil((XLEN+1)/R).

Decomposition:
- Shared package: R = 2^LOGR, the padding constant 4, and the FSM state enum typedef.
- Reuse the existing combinational lzc module, instantiated twice.
- One natural sub-module is intdiv_absneg: the W64 extend plus conditional negate, instantiated for A and B.

Test Plan:
- divu 100/7, Signed=0, W64=0, LOGR=1:
  - OutValid at T+2.
  - ShiftAmtA=57, ShiftAmtB=61, IntCycles=3.
  - NegQuot=0 and all flags 0.
- div -100/7, Signed=1:
  - |A|=100, NegQuot=1, NegRem=1.
  - ShiftAmt values match the divu case.
- divw 0x80000000 / 0xFFFFFFFF, Signed=1, W64=1 -> Overflow=1, |A|=0x80000000, ShiftAmtA=32.
- B=0, A=5 -> DivByZero=1, IntCycles=0, NegQuot=0, ShiftAmtB=64.
- Backpressure and abort:
  - Hold OutReady=0 for 5 cycles: outputs stay stable and InReady=0 throughout.
  - Release OutReady: OutValid drops next cycle and InReady returns 1.
  - Flush asserted in ABS: no OutValid follows, and IDLE is entered the next cycle.
- Assert reset asynchronously mid-LZC -> OutValid=0 and flags 0 immediately; after release, InReady=1.
